interrupt_ack_sequencer: RTL and testbench

- CPU-side end of the interrupt path. Consumes the masked request vector produced by the mask stage and raises INT to the CPU.
- Runs the 8086-mode two-pulse INTA handshake, maintains the In-Service Register (ISR) and returns the interrupt vector byte.
- Handles non-specific, specific and automatic EOI.
- Sits between the mask stage and the data-bus buffer / control logic.

---
 rtl/interrupt_ack_sequencer.sv | 127 ++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: raises INT, runs the two-pulse INTA
// handshake, tracks the in-service register and returns the vector byte.
module interrupt_ack_sequencer #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               intaPulse,
    input  logic [4:0]         vectorBase,
    input  logic               autoEoi,
    input  logic               eoiStrobe,
    input  logic               eoiSpecific,
    input  logic [2:0]         eoiLevel,
    output logic               intOut,
    output logic [7:0]         dataOut,
    output logic               dataOutValid,
    output logic [NUM_IRQ-1:0] inService
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitInta1,
        StWaitInta2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [2:0]         level_q, level_d;
    logic               spurious_q, spurious_d;
    logic               int_q, int_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;

    logic [NUM_IRQ-1:0] lowest_isr;
    logic [NUM_IRQ-1:0] elig_mask;
    logic               elig_valid;
    logic [2:0]         elig_level;

    // Eligible request: irq bits strictly below the lowest in-service bit.
    // With an empty ISR, lowest_isr - 1 wraps to all ones.
    always_comb begin
        lowest_isr = isr_q & (~isr_q + NUM_IRQ'(1));
        elig_mask  = irq & (lowest_isr - NUM_IRQ'(1));
        elig_valid = |elig_mask;
        elig_level = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig_mask[i]) elig_level = 3'(i);
        end
    end

    // Handshake FSM and ISR next state; EOI is applied before any ISR set.
    always_comb begin
        state_d    = state_q;
        isr_d      = isr_q;
        level_d    = level_q;
        spurious_d = spurious_q;
        int_d      = int_q;
        data_d     = data_q;
        valid_d    = 1'b0;

        if (eoiStrobe) begin
            if (eoiSpecific) isr_d[eoiLevel] = 1'b0;
            else             isr_d = isr_q & (isr_q - NUM_IRQ'(1));
        end

        case (state_q)
            StIdle: begin
                if (elig_valid) begin
                    int_d   = 1'b1;
                    state_d = StWaitInta1;
                end
            end
            StWaitInta1: begin
                if (intaPulse) begin
                    if (elig_valid) begin
                        isr_d[elig_level] = 1'b1;
                        level_d           = elig_level;
                        spurious_d        = 1'b0;
                    end else begin
                        // Request vanished before INTA1: report IR7.
                        level_d    = 3'd7;
                        spurious_d = 1'b1;
                    end
                    int_d   = 1'b0;
                    state_d = StWaitInta2;
                end
            end
            StWaitInta2: begin
                if (intaPulse) begin
                    data_d  = {vectorBase, level_q};
                    valid_d = 1'b1;
                    if (autoEoi && !spurious_q) isr_d[level_q] = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            isr_q      <= '0;
            level_q    <= 3'd0;
            spurious_q <= 1'b0;
            int_q      <= 1'b0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            isr_q      <= isr_d;
            level_q    <= level_d;
            spurious_q <= spurious_d;
            int_q      <= int_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign intOut       = int_q;
    assign dataOut      = data_q;
    assign dataOutValid = valid_q;
    assign inService    = isr_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench for interrupt_ack_sequencer: a driver applies directed and
// random cycles and predicts the post-edge outputs; a monitor compares them.
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq;
    logic       intaPulse;
    logic [4:0] vectorBase;
    logic       autoEoi;
    logic       eoiStrobe;
    logic       eoiSpecific;
    logic [2:0] eoiLevel;
    logic       intOut;
    logic [7:0] dataOut;
    logic       dataOutValid;
    logic [7:0] inService;

    always #5 clk = ~clk;

    interrupt_ack_sequencer #(.NUM_IRQ(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .intaPulse    (intaPulse),
        .vectorBase   (vectorBase),
        .autoEoi      (autoEoi),
        .eoiStrobe    (eoiStrobe),
        .eoiSpecific  (eoiSpecific),
        .eoiLevel     (eoiLevel),
        .intOut       (intOut),
        .dataOut      (dataOut),
        .dataOutValid (dataOutValid),
        .inService    (inService)
    );

    typedef struct packed {
        logic       int_o;
        logic [7:0] isr;
        logic       valid;
        logic [7:0] data;
    } exp_t;

    exp_t       sq[$];
    logic [7:0] vq[$];
    int         n_vec  = 0;
    int         n_miss = 0;

    // Reference model: handshake phase 0/1/2 and ISR as a plain bit set.
    int         m_phase = 0;
    logic [7:0] m_isr   = 8'd0;
    int         m_lvl   = 0;
    bit         m_spur  = 1'b0;
    logic       m_int   = 1'b0;
    logic [7:0] m_data  = 8'd0;
    logic       m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Highest-priority request that outranks everything in service, else -1.
    function automatic int winner(input logic [7:0] r, input logic [7:0] s);
        for (int i = 0; i < 8; i++) begin
            if (s[i]) return -1;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic rst, input logic [7:0] r, input logic inta,
                         input logic [4:0] base, input logic aeoi, input logic eoi,
                         input logic spec, input logic [2:0] lvl);
        logic [7:0] nisr;
        int         w;
        @(negedge clk);
        reset = rst; irq = r; intaPulse = inta; vectorBase = base;
        autoEoi = aeoi; eoiStrobe = eoi; eoiSpecific = spec; eoiLevel = lvl;

        m_valid = 1'b0;
        if (rst) begin
            m_phase = 0; m_isr = 8'd0; m_lvl = 0; m_spur = 1'b0;
            m_int = 1'b0; m_data = 8'd0;
        end else begin
            nisr = m_isr;
            if (eoi) begin
                if (spec) nisr[lvl] = 1'b0;
                else begin
                    for (int i = 0; i < 8; i++) begin
                        if (nisr[i]) begin
                            nisr[i] = 1'b0;
                            break;
                        end
                    end
                end
            end
            w = winner(r, m_isr);
            if (m_phase == 0) begin
                if (w >= 0) begin
                    m_int = 1'b1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (inta) begin
                    if (w >= 0) begin
                        nisr[w] = 1'b1; m_lvl = w; m_spur = 1'b0;
                    end else begin
                        m_lvl = 7; m_spur = 1'b1;
                    end
                    m_int = 1'b0;
                    m_phase = 2;
                end
            end else begin
                if (inta) begin
                    m_data = {base, 3'(m_lvl)};
                    m_valid = 1'b1;
                    vq.push_back(m_data);
                    if (aeoi && !m_spur) nisr[m_lvl] = 1'b0;
                    m_phase = 0;
                end
            end
            m_isr = nisr;
        end
        sq.push_back('{int_o: m_int, isr: m_isr, valid: m_valid, data: m_data});
    endtask

    task automatic idle(input logic [7:0] r, input logic [4:0] base, input logic aeoi);
        drive(1'b0, r, 1'b0, base, aeoi, 1'b0, 1'b0, 3'd0);
    endtask

    // Monitor: compare every cycle's outputs; retire a vector on each valid.
    initial begin
        exp_t       e;
        logic [7:0] v;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("intOut", 32'(intOut), 32'(e.int_o));
                chk("inService", 32'(inService), 32'(e.isr));
                chk("dataOutValid", 32'(dataOutValid), 32'(e.valid));
                chk("dataOut", 32'(dataOut), 32'(e.data));
            end
            if (dataOutValid === 1'b1) begin
                if (vq.size() == 0) chk("vector_unexpected", 32'(dataOut), 32'hFFFF_FFFF);
                else begin
                    v = vq.pop_front();
                    chk("vector", 32'(dataOut), 32'(v));
                end
            end
        end
    end

    initial begin
        logic [4:0] base;
        logic       aeoi;
        logic [7:0] r;

        // Reset, then IR2 through a full handshake (vector 8'h42).
        drive(1'b1, 8'h00, 1'b0, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 8'h00, 1'b0, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(8'h04, 5'h08, 1'b0);
        drive(1'b0, 8'h04, 1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(8'h00, 5'h08, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 8'h00, 1'b0, 5'h08, 1'b0, 1'b1, 1'b0, 3'd0);
        // IR1 beats IR3, IR3 held pending until the non-specific EOI.
        idle(8'h0A, 5'h08, 1'b0);
        drive(1'b0, 8'h0A, 1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 8'h0A, 1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(8'h08, 5'h08, 1'b0);
        idle(8'h08, 5'h08, 1'b0);
        drive(1'b0, 8'h08, 1'b0, 5'h08, 1'b0, 1'b1, 1'b0, 3'd0);
        idle(8'h08, 5'h08, 1'b0);
        drive(1'b0, 8'h08, 1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 8'h00, 1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 8'h00, 1'b0, 5'h08, 1'b0, 1'b1, 1'b1, 3'd3);
        // Spurious: IR5 drops before INTA1.
        idle(8'h20, 5'h08, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 8'h00, 1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0);
        // AEOI with IR7.
        idle(8'h80, 5'h08, 1'b1);
        drive(1'b0, 8'h80, 1'b1, 5'h08, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 8'h00, 1'b1, 5'h08, 1'b1, 1'b0, 1'b0, 3'd0);
        // Reset in WAIT_INTA2, then a stray INTA in IDLE.
        idle(8'h01, 5'h10, 1'b0);
        drive(1'b0, 8'h01, 1'b1, 5'h10, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 8'h00, 1'b0, 5'h10, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 8'h00, 1'b1, 5'h10, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(8'h00, 5'h10, 1'b0);

        // Randomized traffic.
        base = 5'h08;
        aeoi = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) base = 5'($urandom);
            if ($urandom_range(0, 99) == 0) aeoi = ~aeoi;
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
            drive($urandom_range(0, 199) == 0, r, $urandom_range(0, 2) == 0, base, aeoi,
                  $urandom_range(0, 7) == 0, 1'($urandom), 3'($urandom));
        end

        idle(8'h00, base, aeoi);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", 32'(sq.size() + vq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
